// File: rtl/ntt_pkg.sv
// Shared constants for the NTT datapath: default modulus/width and the add/sub opcode values.
package ntt_pkg;

    localparam int NTT_Q     = 12289;
    localparam int NTT_WIDTH = 14;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_reduce_stage.sv
// Second pipeline stage of the modular adder: one conditional subtract of Q, registered,
// with a valid flag that holds while the downstream stalls.
module mod_reduce_stage #(
    parameter int WIDTH = 14,
    parameter int Q     = 12289
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH:0]   raw,
    input  logic             out_ready,
    output logic             load,
    output logic             out_valid,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

    logic [WIDTH-1:0] reduced;

    // The stage can take a new value when it is empty or its current value leaves this cycle.
    assign load    = in_valid & (~out_valid | out_ready);
    assign reduced = WIDTH'((raw >= QX) ? (raw - QX) : raw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                result    <= reduced;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_add_sub_pipe.sv
// Two-stage pipelined (a +/- b) mod Q with valid/ready on both sides.
// Optional sticky operand range check when MODADD_RANGE_CHECK_EN is defined.
module mod_add_sub_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH = NTT_WIDTH,
    parameter int Q     = NTT_Q
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef MODADD_RANGE_CHECK_EN
    ,
    output logic             range_err,
    input  logic             err_clr
`endif
);

    localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

    logic             s1_valid;
    logic [WIDTH:0]   s1_raw;
    logic [WIDTH:0]   raw_next;
    logic             s2_load;
    logic             accept;

    // in_ready looks through to out_ready so a full pipe still streams one beat per cycle.
    assign in_ready = ~s1_valid | s2_load;
    assign accept   = in_valid & in_ready;

    // Subtraction adds Q first so the raw value never goes negative for in-range operands.
    always_comb begin
        raw_next = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD: raw_next = {1'b0, a} + {1'b0, b};
            OP_SUB: raw_next = {1'b0, a} + QX - {1'b0, b};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_raw   <= raw_next;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    mod_reduce_stage #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_reduce (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .raw       (s1_raw),
        .out_ready (out_ready),
        .load      (s2_load),
        .out_valid (out_valid),
        .result    (result)
    );

`ifdef MODADD_RANGE_CHECK_EN
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

    logic bad_beat;

    assign bad_beat = accept & ((a >= QW) | (b >= QW));

    // Sticky; a new offending beat outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err <= 1'b0;
        end else begin
            range_err <= bad_beat | (range_err & ~err_clr);
        end
    end
`endif

endmodule
